// File: rtl/tpu_bank_ring_ctrl.sv
// N-bank ring buffer manager: producer/consumer bank ownership,
// physical address translation and sticky protocol error flags.
module tpu_bank_ring_ctrl #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = $clog2(NUM_BANKS),
  parameter int LOCAL_AW  = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_commit,
  input  logic                         wr_en,
  input  logic [LOCAL_AW-1:0]          wr_local_addr,
  input  logic                         rd_release,
  input  logic                         rd_en,
  input  logic [LOCAL_AW-1:0]          rd_local_addr,
  input  logic                         flush,
  input  logic                         cfg_wr,
  input  logic [BANK_W:0]              cfg_nbanks,
  input  logic                         err_clr,
  output logic [BANK_W-1:0]            wr_bank,
  output logic                         wr_ready,
  output logic [BANK_W-1:0]            rd_bank,
  output logic                         rd_valid,
  output logic [BANK_W:0]              count,
  output logic [BANK_W:0]              active_banks,
  output logic                         wr_phys_en,
  output logic [BANK_W+LOCAL_AW-1:0]   wr_phys_addr,
  output logic                         rd_phys_en,
  output logic [BANK_W+LOCAL_AW-1:0]   rd_phys_addr,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_cfg
);

  localparam int CNT_W = BANK_W + 1;
  localparam int PA_W  = BANK_W + LOCAL_AW;
  localparam logic [CNT_W-1:0] ACT_MAX = CNT_W'(NUM_BANKS);
  localparam logic [CNT_W-1:0] ACT_MIN = CNT_W'(2);

  logic [BANK_W-1:0] wr_ptr_q, wr_ptr_n;
  logic [BANK_W-1:0] rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CNT_W-1:0]  act_q, act_n;
  logic [CNT_W-1:0]  act_cfg;
  logic              eo_q, eo_n;
  logic              eu_q, eu_n;
  logic              ec_q, ec_n;
  logic              wpe_q, rpe_q;
  logic [PA_W-1:0]   wpa_q, rpa_q;

  logic is_full, is_empty;
  logic cmt_ok, rel_ok;
  logic ovf, unf;
  logic cfg_take, cfg_rej;

  function automatic logic [BANK_W-1:0] ring_next(
    input logic [BANK_W-1:0] p,
    input logic [CNT_W-1:0]  a
  );
    if ({1'b0, p} == a - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  assign is_full  = (cnt_q >= act_q);
  assign is_empty = (cnt_q == '0);

  assign cfg_take = !flush && cfg_wr && is_empty;
  assign cfg_rej  = !flush && cfg_wr && !is_empty;

  // commit/release are dropped silently under flush or an accepted cfg
  assign cmt_ok = !flush && !cfg_take && wr_commit && !is_full;
  assign rel_ok = !flush && !cfg_take && rd_release && !is_empty;
  assign ovf    = !flush && !cfg_take && wr_commit && is_full;
  assign unf    = !flush && !cfg_take && rd_release && is_empty;

  always_comb begin
    act_cfg = cfg_nbanks;
    if (cfg_nbanks < ACT_MIN) act_cfg = ACT_MIN;
    else if (cfg_nbanks > ACT_MAX) act_cfg = ACT_MAX;
  end

  always_comb begin
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    cnt_n    = cnt_q;
    act_n    = act_q;
    unique case (1'b1)
      flush: begin
        wr_ptr_n = '0;
        rd_ptr_n = '0;
        cnt_n    = '0;
      end
      cfg_take: begin
        act_n    = act_cfg;
        wr_ptr_n = '0;
        rd_ptr_n = '0;
      end
      default: begin
        if (cmt_ok) wr_ptr_n = ring_next(wr_ptr_q, act_q);
        if (rel_ok) rd_ptr_n = ring_next(rd_ptr_q, act_q);
        unique case ({cmt_ok, rel_ok})
          2'b10:   cnt_n = cnt_q + 1'b1;
          2'b01:   cnt_n = cnt_q - 1'b1;
          default: cnt_n = cnt_q;
        endcase
      end
    endcase
  end

  // a fresh error beats err_clr in the same cycle
  assign eo_n = (eo_q && !err_clr) || ovf;
  assign eu_n = (eu_q && !err_clr) || unf;
  assign ec_n = (ec_q && !err_clr) || cfg_rej;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      act_q    <= ACT_MAX;
      eo_q     <= 1'b0;
      eu_q     <= 1'b0;
      ec_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      cnt_q    <= cnt_n;
      act_q    <= act_n;
      eo_q     <= eo_n;
      eu_q     <= eu_n;
      ec_q     <= ec_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wpe_q <= 1'b0;
      rpe_q <= 1'b0;
      wpa_q <= '0;
      rpa_q <= '0;
    end else begin
      wpe_q <= wr_en;
      rpe_q <= rd_en;
      wpa_q <= {wr_ptr_q, wr_local_addr};
      rpa_q <= {rd_ptr_q, rd_local_addr};
    end
  end

  assign wr_bank       = wr_ptr_q;
  assign rd_bank       = rd_ptr_q;
  assign wr_ready      = !is_full;
  assign rd_valid      = !is_empty;
  assign count         = cnt_q;
  assign active_banks  = act_q;
  assign wr_phys_en    = wpe_q;
  assign wr_phys_addr  = wpa_q;
  assign rd_phys_en    = rpe_q;
  assign rd_phys_addr  = rpa_q;
  assign err_overflow  = eo_q;
  assign err_underflow = eu_q;
  assign err_cfg       = ec_q;

endmodule

// File: doc/tpu_bank_ring_ctrl.md
# tpu_bank_ring_ctrl

Parametrised N-bank ring buffer manager: the successor to the fixed ping-pong `ub_buf_sel`/`acc_buf_sel` toggle in the TPU controller. It tracks which bank a producer (DMA, systolic array) writes and which bank a consumer (systolic array, VPU) reads. It also translates local addresses into physical `{bank, local}` addresses and flags protocol errors. It sits between `tpu_controller` and the unified-buffer/accumulator memories; one instance per buffered memory.

## Interface
- `NUM_BANKS`, 4: physical banks, power of 2, ≥2.
- `BANK_W`, $clog2(NUM_BANKS): bank index width.
- `LOCAL_AW`, 7: in-bank address width.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_commit`  in  1  producer finished filling `wr_bank`.
- `wr_en`  in  1  producer write strobe.
- `wr_local_addr`  in  LOCAL_AW  producer in-bank address.
- `rd_release`  in  1  consumer finished with `rd_bank`.
- `rd_en`  in  1  consumer read strobe.
- `rd_local_addr`  in  LOCAL_AW  consumer in-bank address.
- `flush`  in  1  synchronous ring reset.
- `cfg_wr`  in  1  load active bank count.
- `cfg_nbanks`  in  BANK_W+1  requested active bank count.
- `err_clr`  in  1  clear sticky errors.
- `wr_bank`  out  BANK_W  bank currently owned by the producer.
- `wr_ready`  out  1  a free bank exists (`count < active`).
- `rd_bank`  out  BANK_W  oldest full bank.
- `rd_valid`  out  1  a full bank exists (`count > 0`).
- `count`  out  BANK_W+1  number of full banks.
- `active_banks`  out  BANK_W+1  active ring size.
- `wr_phys_en` / `wr_phys_addr`  out  1 / BANK_W+LOCAL_AW  registered write strobe and physical address.
- `rd_phys_en` / `rd_phys_addr`  out  1 / BANK_W+LOCAL_AW  registered read strobe and physical address.
- `err_overflow`, `err_underflow`, `err_cfg`  out  1 each  sticky error flags.

## Operation
- State: `wr_ptr`, `rd_ptr` (BANK_W), `count` (0..active), `active` (2..NUM_BANKS). Outputs `wr_bank = wr_ptr`, `rd_bank = rd_ptr`.
- Commit with `count < active`:
  - `wr_ptr` advances and wraps from `active-1` to 0.
  - `count` increments.
- Commit with `count == active`: ignored, `err_overflow` set.
- Release with `count > 0`:
  - `rd_ptr` advances and wraps from `active-1` to 0.
  - `count` decrements.
- Release with `count == 0`: ignored, `err_underflow` set.
- Legality of both commit and release is judged on the pre-edge `count`:
  - Commit while full is an overflow even if a release occurs in the same cycle. That release still takes effect.
  - Release while empty is an underflow even if a commit occurs in the same cycle. That commit still takes effect.
  - A legal commit and a legal release in the same cycle: both pointers advance, `count` is unchanged.
- `flush`: `wr_ptr`, `rd_ptr` and `count` go to 0. It overrides commit, release and cfg in the same cycle. Errors and `active` are retained.
- `cfg_wr` (and no `flush`):
  - Accepted only when `count == 0`.
  - `active` is set to `cfg_nbanks` clamped to [2, NUM_BANKS], and both pointers go to 0.
  - Any commit or release in that cycle is ignored without error.
  - If `count != 0`: ignored, `err_cfg` set.
- With `active = 2` the block reproduces the legacy ping-pong behaviour.
- Address translation: each phys address is `{bank pointer value at sampling edge, local addr}`.
  - A `wr_en` in the same cycle as `wr_commit` uses the old (pre-commit) bank.
  - A `rd_en` in the same cycle as `rd_release` uses the old bank.
- Errors:
  - `err_clr` clears all three flags.
  - A new error in the same cycle as `err_clr` wins: the flag stays set.

## Timing
- Reset values:
  - Pointers, `count`, `wr_bank`, `rd_bank`: 0.
  - `wr_ready` 1, `rd_valid` 0.
  - `active` = NUM_BANKS.
  - All errors 0.
  - `*_phys_en` 0, `*_phys_addr` 0.
- Reset mid-operation discards all ring state immediately; full banks are forgotten.
- Pointer, count and flag updates are visible the cycle after the command edge.
- `wr_ready`, `rd_valid`, `wr_bank`, `rd_bank` are combinational from registered state; no input-to-output combinational path.
- Phys strobes and addresses have 1-cycle latency and are registered every cycle. `flush`/`cfg` do not cancel an in-flight phys strobe.

## Test plan
- Reset, NUM_BANKS=4: three commits then one release. Expect `count` 1→2→3→2, `wr_bank` = 3, `rd_bank` = 1, `wr_ready` = 1, `rd_valid` = 1.
- Four commits, then a fifth commit in the same cycle as a release:
  - After four commits: `count` = 4, `wr_ready` = 0.
  - Fifth commit + release: `err_overflow` = 1, `count` = 3, `rd_bank` = 1, `wr_bank` = 0.
- From empty, release in the same cycle as a commit: `err_underflow` = 1, `count` = 1. Then `err_clr`: flag reads 0 next cycle.
- `cfg_nbanks` = 2 at empty, then alternate commit/release for 6 pairs: `wr_bank` and `rd_bank` toggle 0/1 and never reach 2. `cfg_wr` with `count` = 1: `err_cfg` = 1, `active` stays 2.
- `cfg_nbanks` = 1 and `cfg_nbanks` = 7 (at empty): `active` reads 2 and 4 respectively.
- `wr_ptr` = 2, `wr_en` + `wr_commit` with local 0x05: next cycle `wr_phys_addr` = {2, 0x05} = 0x105, `wr_phys_en` = 1, `wr_bank` = 3. Flush with commit pending: `count` = 0, pointers 0.
